axi_lite_cmd_master: RTL and testbench

//  AXI4-Lite initiator: turns one register command from a local valid/ready port into a single AXI4-Lite read or write.

---
 rtl/axi_lite_cmd_master_if.sv | 31 +++
 rtl/axi_lite_cmd_master.sv | 100 ++++++++++
 tb/tb_axi_lite_cmd_master.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cmd_master_if.sv
// axi_lite_cmd_master_if: AXI4-Lite channel bundle between an initiator and a register slave
interface axi_lite_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns one local register command into a single AXI4-Lite read or write
module axi_lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_TIMEOUT          = 256
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_areset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    axi_lite_cmd_master_if.master           m_axi
);
    typedef enum logic [2:0] {IDLE, WR_AW, WR_B, RD_A, RD_R, DONE} state_t;
    state_t state, state_n;
    logic aw_pend, w_pend, aw_n, w_n;
    logic accept, busy, expire, wr_ok, rd_ok;
    logic [31:0] age;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
    assign accept = cmd_valid & cmd_ready;
    assign busy   = state != IDLE && state != DONE;
    // age counts cycles since accept with the accept cycle as the first one
    assign expire = C_TIMEOUT != 0 && age >= 32'(C_TIMEOUT - 1);
    assign wr_ok  = state == WR_B && m_axi.bvalid;
    assign rd_ok  = state == RD_R && m_axi.rvalid;
    always_comb begin
        state_n = state;
        aw_n = aw_pend & ~m_axi.awready;
        w_n = w_pend & ~m_axi.wready;
        case (state)
            IDLE: begin
                state_n = accept ? (cmd_rnw ? RD_A : WR_AW) : IDLE;
                aw_n = accept & ~cmd_rnw;
                w_n = accept & ~cmd_rnw;
            end
            WR_AW: begin
                state_n = !(aw_n || w_n) ? WR_B : expire ? DONE : WR_AW;
                aw_n = aw_n & ~expire;
                w_n = w_n & ~expire;
            end
            WR_B: state_n = (m_axi.bvalid || expire) ? DONE : WR_B;
            RD_A: state_n = m_axi.arready ? RD_R : expire ? DONE : RD_A;
            RD_R: state_n = (m_axi.rvalid || expire) ? DONE : RD_R;
            DONE: state_n = rsp_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state <= IDLE;
            aw_pend <= 1'b0;
            w_pend <= 1'b0;
            cmd_ready <= 1'b0;
            age <= '0;
            addr <= '0;
            wdata <= '0;
            wstrb <= '0;
            rsp_rdata <= '0;
            rsp_resp <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_n;
            aw_pend <= aw_n;
            w_pend <= w_n;
            cmd_ready <= state_n == IDLE;
            age <= accept ? 32'd1 : busy ? age + 32'd1 : age;
            if (accept) begin
                addr <= cmd_addr;
                wdata <= cmd_wdata;
                wstrb <= cmd_wstrb;
            end
            // a response arriving in the expiry cycle still counts as a normal completion
            if (busy && state_n == DONE) begin
                rsp_rdata <= rd_ok ? m_axi.rdata : '0;
                rsp_resp <= rd_ok ? m_axi.rresp : wr_ok ? m_axi.bresp : 2'b10;
                rsp_timeout <= !(rd_ok || wr_ok);
            end
        end
    end
    assign m_axi.awaddr  = addr;
    assign m_axi.awvalid = aw_pend;
    assign m_axi.wdata   = wdata;
    assign m_axi.wstrb   = wstrb;
    assign m_axi.wvalid  = w_pend;
    assign m_axi.bready  = state == WR_B;
    assign m_axi.araddr  = addr;
    assign m_axi.arvalid = state == RD_A;
    assign m_axi.rready  = state == RD_R;
    assign rsp_valid     = state == DONE;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: directed vectors plus hand sequences against a small AXI4-Lite slave model
module tb_axi_lite_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    axi_lite_cmd_master_if #(.AW(32), .DW(32)) bus ();
    axi_lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(32),
        .C_TIMEOUT(16)
    ) dut (
        .m_axi_aclk(clk),
        .m_axi_areset(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m_axi(bus)
    );

    // slave model: per-channel ready delays, response delay, hang switch, response codes
    int          aw_delay = 0;
    int          w_delay = 0;
    int          b_delay = 0;
    logic        ar_hang = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [31:0] mem [16];
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    int          aw_wait, w_wait, b_wait;
    int          aw_beats = 0;
    int          w_beats = 0;
    int          rsp_cnt = 0;
    logic [31:0] last_awaddr = '0;
    logic [31:0] last_araddr = '0;
    logic        aw_hs, w_hs, ar_hs, aw_ok, w_ok;
    logic [31:0] a_now, d_now;
    logic [3:0]  s_now;
    assign bus.awready = bus.awvalid && aw_wait >= aw_delay;
    assign bus.wready  = bus.wvalid && w_wait >= w_delay;
    assign bus.arready = bus.arvalid && !ar_hang;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;
    assign aw_ok = aw_got || aw_hs;
    assign w_ok  = w_got || w_hs;
    assign a_now = aw_got ? aw_a : bus.awaddr;
    assign d_now = w_got ? w_d : bus.wdata;
    assign s_now = w_got ? w_s : bus.wstrb;

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0;
            w_got <= 1'b0;
            aw_a <= '0;
            w_d <= '0;
            w_s <= '0;
            aw_wait <= 0;
            w_wait <= 0;
            b_wait <= 0;
            bus.bvalid <= 1'b0;
            bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0;
            bus.rresp <= 2'b00;
            bus.rdata <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            aw_wait <= (bus.awvalid && !aw_hs) ? aw_wait + 1 : 0;
            w_wait <= (bus.wvalid && !w_hs) ? w_wait + 1 : 0;
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_a <= bus.awaddr;
                last_awaddr <= bus.awaddr;
                aw_beats <= aw_beats + 1;
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_d <= bus.wdata;
                w_s <= bus.wstrb;
                w_beats <= w_beats + 1;
            end
            if (aw_ok && w_ok && !bus.bvalid) begin
                if (b_wait >= b_delay) begin
                    bus.bvalid <= 1'b1;
                    bus.bresp <= b_resp_cfg;
                    for (int i = 0; i < 4; i++)
                        if (s_now[i]) mem[a_now[5:2]][8*i +: 8] <= d_now[8*i +: 8];
                    aw_got <= 1'b0;
                    w_got <= 1'b0;
                    b_wait <= 0;
                end else begin
                    b_wait <= b_wait + 1;
                end
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (ar_hs) begin
                bus.rvalid <= 1'b1;
                bus.rdata <= mem[bus.araddr[5:2]];
                bus.rresp <= r_resp_cfg;
                last_araddr <= bus.araddr;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    always @(posedge clk) if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {cmd_ready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata,
                bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready};
    endfunction

    task automatic issue(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_rnw = rnw;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_seen", rsp_valid, 1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
    endtask

    task automatic run_cmd(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output logic [1:0] rs, output logic to, output int lat);
        issue(rnw, a, d, s);
        wait_rsp(1, lat);
        rd = rsp_rdata;
        rs = rsp_resp;
        to = rsp_timeout;
        finish_rsp();
    endtask

    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp_cfg;
        logic [1:0]  rresp_cfg;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs [7];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to;
        int          lat, base_aw, base_w, base_rsp, n;
        logic [34:0] snap;
        logic        quiet;
        vecs[0] = '{1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 2'd0, 2'd0, 32'h0, 2'd0};
        vecs[1] = '{1'b1, 32'h10, 32'h0, 4'h0, 2'd0, 2'd0, 32'hDEADBEEF, 2'd0};
        vecs[2] = '{1'b0, 32'h14, 32'h12345678, 4'h3, 2'd0, 2'd0, 32'h0, 2'd0};
        vecs[3] = '{1'b1, 32'h14, 32'h0, 4'h0, 2'd0, 2'd0, 32'h00005678, 2'd0};
        vecs[4] = '{1'b0, 32'h18, 32'hA5A5A5A5, 4'hF, 2'd2, 2'd0, 32'h0, 2'd2};
        vecs[5] = '{1'b1, 32'h18, 32'h0, 4'h0, 2'd0, 2'd2, 32'hA5A5A5A5, 2'd2};
        vecs[6] = '{1'b1, 32'h1C, 32'h0, 4'h0, 2'd0, 2'd3, 32'h0, 2'd3};
        repeat (3) @(negedge clk);
        check("reset_state", outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < 7; i++) begin
            b_resp_cfg = vecs[i].bresp_cfg;
            r_resp_cfg = vecs[i].rresp_cfg;
            run_cmd(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, rs, to, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_resp", i), rs, vecs[i].exp_resp);
            check($sformatf("vec%0d_timeout", i), to, 0);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_bus_addr", i), vecs[i].rnw ? last_araddr : last_awaddr, vecs[i].addr);
        end
        b_resp_cfg = 2'b00;
        r_resp_cfg = 2'b00;

        // W accepted four cycles before AW, then B after two stall cycles
        aw_delay = 4;
        b_delay = 2;
        base_aw = aw_beats;
        base_w = w_beats;
        base_rsp = rsp_cnt;
        issue(1'b0, 32'h20, 32'h0BADF00D, 4'hF);
        check("split_c1_valids", {bus.awvalid, bus.wvalid}, 2'b11);
        @(negedge clk);
        check("split_c2_w_dropped", {bus.awvalid, bus.wvalid}, 2'b10);
        repeat (3) @(negedge clk);
        check("split_c5_aw_held", {bus.awvalid, bus.wvalid}, 2'b10);
        wait_rsp(5, lat);
        check("split_latency", lat, 9);
        check("split_resp", {rsp_timeout, rsp_resp, rsp_rdata}, 0);
        finish_rsp();
        repeat (3) @(negedge clk);
        check("split_one_rsp", rsp_cnt - base_rsp, 1);
        check("split_one_aw", aw_beats - base_aw, 1);
        check("split_one_w", w_beats - base_w, 1);
        aw_delay = 0;
        b_delay = 0;

        // result held back five cycles while a new command waits
        issue(1'b1, 32'h10, 32'h0, 4'h0);
        wait_rsp(1, lat);
        check("hold_latency", lat, 3);
        snap = {rsp_rdata, rsp_resp, rsp_timeout};
        check("hold_rdata", snap, {32'hDEADBEEF, 2'b00, 1'b0});
        cmd_valid = 1'b1;
        cmd_rnw = 1'b0;
        cmd_addr = 32'h28;
        cmd_wdata = 32'h11112222;
        cmd_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_stable", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, snap});
            check("hold_not_accepted", {cmd_ready, bus.awvalid, bus.arvalid}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold_release", {cmd_ready, rsp_valid, bus.awvalid}, 3'b100);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold_next_accepted", {cmd_ready, bus.awvalid, bus.wvalid}, 3'b011);
        wait_rsp(1, lat);
        check("hold_next_latency", lat, 3);
        finish_rsp();

        // slave never accepts AR
        ar_hang = 1'b1;
        issue(1'b1, 32'h10, 32'h0, 4'h0);
        wait_rsp(1, lat);
        check("timeout_latency", lat, 16);
        check("timeout_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'h0});
        check("timeout_ar_dropped", {bus.arvalid, bus.rready}, 2'b00);
        finish_rsp();
        ar_hang = 1'b0;

        // reset while waiting on B, then a DECERR read
        b_delay = 20;
        issue(1'b0, 32'h24, 32'h33334444, 4'hF);
        n = 0;
        while (!bus.bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_wr_b", bus.bready, 1);
        base_rsp = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_state", outs(), 0);
        rst = 1'b0;
        b_delay = 0;
        quiet = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            quiet = quiet | rsp_valid;
        end
        check("no_stale_rsp", {quiet, 32'(rsp_cnt - base_rsp)}, 0);
        r_resp_cfg = 2'b11;
        run_cmd(1'b1, 32'h24, 32'h0, 4'h0, rd, rs, to, lat);
        check("decerr_resp", {to, rs}, {1'b0, 2'b11});
        check("decerr_rdata", rd, 32'h0);
        r_resp_cfg = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
